// File: rtl/montgomery_batch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : montgomery_batch_ctrl
//  Description : Batch scheduler for the pipelined Montgomery reducer.
//                It accepts {base, length} commands and streams coefficients
//                from a sync-read RAM into the reducer at up to one per cycle.
//                In-order results are buffered in a small FIFO and written
//                back to base+index under sink backpressure. The reducer
//                cannot stall, so a read is issued only when a FIFO slot is
//                already reserved for its result (credit scheme).
//
//  Ports       : clk_i, rst_i         clock, synchronous active-high reset
//                cmd_*                command handshake (base, length)
//                rd_en_o/rd_addr_o    RAM read strobe/address (data next cycle)
//                rd_data_i            RAM read data
//                mul_start_o/mul_x_o  reducer start and operand
//                mul_valid_i/result_i reducer result (fixed latency, in order)
//                wr_*                 result write-back handshake
//                busy_o, done_o       batch status; done_o is a 1-cycle pulse
//                err_o                sticky unexpected-result flag
//                perf_cycles_o        busy-cycle counter (MONT_BATCH_PERF_EN)
//
//  Config      : define MONT_BATCH_PERF_EN to add perf_cycles_o.
//  Revision    : 1.0  initial release
// ============================================================================
module montgomery_batch_ctrl #(
  parameter int DATA_LENGTH = 64,
  parameter int ADDR_W      = 10,
  parameter int MUL_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ADDR_W-1:0]      cmd_base_i,
  input  logic [ADDR_W:0]        cmd_len_i,
  output logic                   rd_en_o,
  output logic [ADDR_W-1:0]      rd_addr_o,
  input  logic [DATA_LENGTH-1:0] rd_data_i,
  output logic                   mul_start_o,
  output logic [DATA_LENGTH-1:0] mul_x_o,
  input  logic                   mul_valid_i,
  input  logic [DATA_LENGTH-1:0] mul_result_i,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [DATA_LENGTH-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
`ifdef MONT_BATCH_PERF_EN
  ,
  output logic [31:0]            perf_cycles_o
`endif
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HOLD_W = $clog2(MUL_LATENCY + 2);

  generate
    if (FIFO_DEPTH < MUL_LATENCY + 2) begin : g_depth_check
      $fatal(1, "montgomery_batch_ctrl: FIFO_DEPTH must be >= MUL_LATENCY+2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]       wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]       in_flight_q;    // reads issued - FIFO pops
  logic [CNT_W-1:0]       outstanding_q;  // reads issued - FIFO pushes
  logic [CNT_W-1:0]       count_q;        // FIFO occupancy
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [DATA_LENGTH-1:0] fifo_q [FIFO_DEPTH];
  logic                   rd_pend_q;
  logic [HOLD_W-1:0]      holdoff_q;
  logic                   err_q;

  logic credit_ok;
  logic push;
  logic stray;
  logic pop;

  // A read may only be issued when its result already has a FIFO slot.
  assign credit_ok = (in_flight_q < CNT_W'(FIFO_DEPTH));

  // Results arriving during the post-reset holdoff belong to an aborted
  // batch still draining out of the reducer; they are silently discarded.
  assign push  = mul_valid_i && (holdoff_q == '0) && (outstanding_q != '0);
  assign stray = mul_valid_i && (holdoff_q == '0) && (outstanding_q == '0);
  assign pop   = wr_valid_o && wr_ready_i;

  assign rd_addr_o   = base_q + rd_idx_q[ADDR_W-1:0];
  assign wr_addr_o   = base_q + wr_idx_q[ADDR_W-1:0];
  assign mul_start_o = rd_pend_q;
  assign mul_x_o     = rd_pend_q ? rd_data_i : '0;
  assign wr_valid_o  = (count_q != '0);
  assign wr_data_o   = wr_valid_o ? fifo_q[rptr_q] : '0;
  assign err_o       = err_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q + {{ADDR_W{1'b0}}, pop};
    cmd_ready_o = 1'b0;
    rd_en_o     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          base_d   = cmd_base_i;
          len_d    = cmd_len_i;
          rd_idx_d = '0;
          wr_idx_d = '0;
          state_d  = (cmd_len_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_o = 1'b1;
        if (credit_ok) begin
          rd_en_o  = 1'b1;
          rd_idx_d = rd_idx_q + LEN_W'(1);
          if (rd_idx_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        // Look at the post-pop index so done_o follows the last write directly.
        if (wr_idx_d == len_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      in_flight_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      rd_pend_q     <= 1'b0;
      holdoff_q     <= HOLD_W'(MUL_LATENCY + 1);
      err_q         <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      rd_pend_q <= rd_en_o;
      if (holdoff_q != '0) begin
        holdoff_q <= holdoff_q - HOLD_W'(1);
      end
      if (stray) begin
        err_q <= 1'b1;
      end
      case ({rd_en_o, pop})
        2'b10:   in_flight_q <= in_flight_q + CNT_W'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_W'(1);
        default: in_flight_q <= in_flight_q;
      endcase
      case ({rd_en_o, push})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push) begin
        wptr_q <= (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: occupancy gates both visibility and output data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= mul_result_i;
    end
  end

`ifdef MONT_BATCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (cmd_ready_o && cmd_valid_i) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule
`default_nettype wire
